// File: rtl/carrier_pkg.sv
// Shared definitions for the carrier-offset phase rotator: table depth defaults,
// controller state encoding and the quadrant-to-table-control mapping.
package carrier_pkg;

  localparam int READ_DEPTH_DEF = 2500;
  localparam int NB_ADDR_DEF    = $clog2(READ_DEPTH_DEF);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic swap;
    logic neg_sin;
    logic neg_cos;
  } quad_ctl_t;

  // Quadrant q selects which quarter table feeds each output and its sign.
  localparam quad_ctl_t QUAD_CTL_Q0 = '{swap: 1'b0, neg_sin: 1'b0, neg_cos: 1'b0};
  localparam quad_ctl_t QUAD_CTL_Q1 = '{swap: 1'b1, neg_sin: 1'b0, neg_cos: 1'b1};
  localparam quad_ctl_t QUAD_CTL_Q2 = '{swap: 1'b0, neg_sin: 1'b1, neg_cos: 1'b1};
  localparam quad_ctl_t QUAD_CTL_Q3 = '{swap: 1'b1, neg_sin: 1'b1, neg_cos: 1'b0};

  function automatic quad_ctl_t quad_ctl(input logic [1:0] q);
    case (q)
      2'd0:    return QUAD_CTL_Q0;
      2'd1:    return QUAD_CTL_Q1;
      2'd2:    return QUAD_CTL_Q2;
      default: return QUAD_CTL_Q3;
    endcase
  endfunction

endpackage

// File: rtl/phase_acc_quarter.sv
// Modular up/down step of a phase held as quadrant q and quarter-table index k,
// so a full turn is 4*READ_DEPTH without any divider.
module phase_acc_quarter #(
  parameter int READ_DEPTH = 2500,
  parameter int NB_ADDR    = 12
) (
  input  logic [NB_ADDR-1:0] k,
  input  logic [1:0]         q,
  input  logic [NB_ADDR-1:0] step,
  input  logic               dir,
  output logic [NB_ADDR-1:0] k_next,
  output logic [1:0]         q_next
);

  localparam logic [NB_ADDR:0] DEPTH = (NB_ADDR+1)'(READ_DEPTH);

  logic [NB_ADDR:0] sum_up;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    sum_up = {1'b0, k} + {1'b0, step};
    k_next = k;
    q_next = q;
    if (!dir) begin
      if (sum_up >= DEPTH) begin
        k_next = NB_ADDR'(sum_up - DEPTH);
        q_next = q + 2'd1;
      end else begin
        k_next = sum_up[NB_ADDR-1:0];
      end
    end else if (k >= step) begin
      k_next = k - step;
    end else begin
      // Borrow one quarter: k + DEPTH - step is always below DEPTH here.
      k_next = NB_ADDR'({1'b0, k} + DEPTH - {1'b0, step});
      q_next = q - 2'd1;
    end
  end

endmodule

// File: rtl/carrier_phase_ctrl.sv
// Carrier phase sequencer: IDLE/RUN control, step configuration handshake with
// symbol-boundary update, and registered ROM address / quadrant controls.
module carrier_phase_ctrl
  import carrier_pkg::*;
#(
  parameter int READ_DEPTH = READ_DEPTH_DEF,
  parameter int NB_ADDR    = $clog2(READ_DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [NB_ADDR-1:0] i_cfg_step,
  input  logic               i_cfg_dir,
  output logic               o_cfg_err,
  output logic [NB_ADDR-1:0] o_addr,
  output logic [1:0]         o_quad,
  output logic               o_swap,
  output logic               o_neg_sin,
  output logic               o_neg_cos,
  output logic               o_valid,
  output logic               o_busy
);

  localparam logic [NB_ADDR:0] DEPTH = (NB_ADDR+1)'(READ_DEPTH);

  state_t             state, state_next;
  logic [NB_ADDR-1:0] k_r, k_next, step_r, pend_step, adv_step;
  logic [1:0]         q_r, q_next;
  logic               dir_r, pend_dir, pend_valid, adv_dir;
  quad_ctl_t          ctl_r;
  logic               advance, clear, cfg_fire, cfg_legal;

  assign cfg_fire  = i_cfg_valid && o_cfg_ready;
  assign cfg_legal = {1'b0, i_cfg_step} < DEPTH;

  // A pending step is consumed by the advance it applies to.
  assign adv_step = pend_valid ? pend_step : step_r;
  assign adv_dir  = pend_valid ? pend_dir  : dir_r;

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    clear      = 1'b0;
    case (state)
      ST_IDLE: if (i_start) begin
        state_next = ST_RUN;
        clear      = 1'b1;
      end
      ST_RUN: begin
        if (i_stop) state_next = ST_IDLE;
        else if (i_enable) advance = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  phase_acc_quarter #(
    .READ_DEPTH(READ_DEPTH),
    .NB_ADDR   (NB_ADDR)
  ) u_acc (
    .k     (k_r),
    .q     (q_r),
    .step  (adv_step),
    .dir   (adv_dir),
    .k_next(k_next),
    .q_next(q_next)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      k_r        <= '0;
      q_r        <= '0;
      ctl_r      <= QUAD_CTL_Q0;
      step_r     <= '0;
      dir_r      <= 1'b0;
      pend_step  <= '0;
      pend_dir   <= 1'b0;
      pend_valid <= 1'b0;
      o_valid    <= 1'b0;
      o_cfg_err  <= 1'b0;
    end else begin
      o_valid   <= advance || clear;
      o_cfg_err <= cfg_fire && !cfg_legal;

      if (clear) begin
        k_r   <= '0;
        q_r   <= '0;
        ctl_r <= QUAD_CTL_Q0;
      end else if (advance) begin
        k_r   <= k_next;
        q_r   <= q_next;
        ctl_r <= quad_ctl(q_next);
      end

      // A step left pending when RUN stops is committed once idle.
      if (pend_valid && (advance || state == ST_IDLE)) begin
        step_r     <= pend_step;
        dir_r      <= pend_dir;
        pend_valid <= 1'b0;
      end

      if (cfg_fire && cfg_legal) begin
        if (state == ST_IDLE) begin
          step_r <= i_cfg_step;
          dir_r  <= i_cfg_dir;
        end else begin
          pend_step  <= i_cfg_step;
          pend_dir   <= i_cfg_dir;
          pend_valid <= 1'b1;
        end
      end
    end
  end

  assign o_addr      = k_r;
  assign o_quad      = q_r;
  assign o_swap      = ctl_r.swap;
  assign o_neg_sin   = ctl_r.neg_sin;
  assign o_neg_cos   = ctl_r.neg_cos;
  assign o_busy      = (state == ST_RUN);
  assign o_cfg_ready = !pend_valid;

endmodule

// File: tb/tb_carrier_phase_ctrl.sv
// Directed bench for carrier_phase_ctrl: phase wrap up/down, quadrant controls,
// config handshake timing, illegal steps, start/stop priority and reset.
module tb_carrier_phase_ctrl;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0, i_start = 1'b0, i_stop = 1'b0;
  logic        i_cfg_valid = 1'b0, i_cfg_dir = 1'b0;
  logic [11:0] i_cfg_step = '0;
  logic        o_cfg_ready, o_cfg_err, o_swap, o_neg_sin, o_neg_cos, o_valid, o_busy;
  logic [11:0] o_addr;
  logic [1:0]  o_quad;

  int checks = 0;
  int errors = 0;

  carrier_phase_ctrl dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready),
    .i_cfg_step (i_cfg_step),
    .i_cfg_dir  (i_cfg_dir),
    .o_cfg_err  (o_cfg_err),
    .o_addr     (o_addr),
    .o_quad     (o_quad),
    .o_swap     (o_swap),
    .o_neg_sin  (o_neg_sin),
    .o_neg_cos  (o_neg_cos),
    .o_valid    (o_valid),
    .o_busy     (o_busy)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (10) tick();
    checks++;
    if ({o_addr, o_quad, o_swap, o_neg_sin, o_neg_cos, o_valid, o_busy, o_cfg_err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d quad=%0d swap=%b nsin=%b ncos=%b valid=%b busy=%b err=%b, all required 0",
               o_addr, o_quad, o_swap, o_neg_sin, o_neg_cos, o_valid, o_busy, o_cfg_err);
    end
    checks++;
    if (o_cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", o_cfg_ready);
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_up_wrap();
    logic [11:0] exp_k [3] = '{12'd1000, 12'd2000, 12'd500};
    logic [1:0]  exp_q [3] = '{2'd0, 2'd0, 2'd1};
    i_cfg_valid = 1'b1; i_cfg_step = 12'd1000; i_cfg_dir = 1'b0;
    tick();
    i_cfg_valid = 1'b0;
    checks++;
    if ({o_cfg_ready, o_cfg_err} !== 2'b10) begin
      errors++;
      $display("FAIL up_cfg_idle: ready=%b err=%b required ready=1 err=0", o_cfg_ready, o_cfg_err);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_addr, o_quad, o_valid, o_busy} !== {12'd0, 2'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL up_start: addr=%0d quad=%0d valid=%b busy=%b required 0 0 1 1", o_addr, o_quad, o_valid, o_busy);
    end
    for (int i = 0; i < 3; i++) begin
      i_enable = 1'b1;
      tick();
      checks++;
      if ({o_addr, o_quad, o_valid} !== {exp_k[i], exp_q[i], 1'b1}) begin
        errors++;
        $display("FAIL up_strobe%0d: k=%0d q=%0d valid=%b required k=%0d q=%0d valid=1",
                 i, o_addr, o_quad, o_valid, exp_k[i], exp_q[i]);
      end
    end
    i_enable = 1'b0;
    checks++;
    if ({o_swap, o_neg_sin, o_neg_cos} !== 3'b101) begin
      errors++;
      $display("FAIL up_q1_ctl: swap/nsin/ncos=%b%b%b required 101", o_swap, o_neg_sin, o_neg_cos);
    end
    tick();
    checks++;
    if ({o_addr, o_valid} !== {12'd500, 1'b0}) begin
      errors++;
      $display("FAIL up_no_strobe: addr=%0d valid=%b required 500 0", o_addr, o_valid);
    end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    checks++;
    if ({o_busy, o_addr, o_quad} !== {1'b0, 12'd500, 2'd1}) begin
      errors++;
      $display("FAIL up_stop: busy=%b addr=%0d quad=%0d required 0 500 1", o_busy, o_addr, o_quad);
    end
  endtask

  task automatic test_down_wrap();
    i_cfg_valid = 1'b1; i_cfg_step = 12'd1; i_cfg_dir = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_enable = 1'b1;
    tick();
    checks++;
    if ({o_addr, o_quad, o_swap, o_neg_sin, o_neg_cos} !== {12'd2499, 2'd3, 3'b110}) begin
      errors++;
      $display("FAIL down_first: k=%0d q=%0d ctl=%b%b%b required k=2499 q=3 ctl=110",
               o_addr, o_quad, o_swap, o_neg_sin, o_neg_cos);
    end
    repeat (2500) tick();
    i_enable = 1'b0;
    checks++;
    if ({o_addr, o_quad, o_swap, o_neg_sin, o_neg_cos} !== {12'd2499, 2'd2, 3'b011}) begin
      errors++;
      $display("FAIL down_full_quarter: k=%0d q=%0d ctl=%b%b%b required k=2499 q=2 ctl=011",
               o_addr, o_quad, o_swap, o_neg_sin, o_neg_cos);
    end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  task automatic test_illegal_step();
    i_cfg_valid = 1'b1; i_cfg_step = 12'd1000; i_cfg_dir = 1'b0;
    tick();
    i_cfg_valid = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_cfg_valid = 1'b1; i_cfg_step = 12'd2500;
    tick();
    i_cfg_valid = 1'b0;
    checks++;
    if ({o_cfg_err, o_cfg_ready} !== 2'b11) begin
      errors++;
      $display("FAIL illegal_err_pulse: err=%b ready=%b required 1 1", o_cfg_err, o_cfg_ready);
    end
    tick();
    checks++;
    if (o_cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_single: err=%b required 0", o_cfg_err);
    end
    i_enable = 1'b1;
    tick();
    checks++;
    if ({o_addr, o_quad} !== {12'd1000, 2'd0}) begin
      errors++;
      $display("FAIL illegal_keeps_step1: k=%0d q=%0d required 1000 0", o_addr, o_quad);
    end
    tick();
    i_enable = 1'b0;
    checks++;
    if ({o_addr, o_quad} !== {12'd2000, 2'd0}) begin
      errors++;
      $display("FAIL illegal_keeps_step2: k=%0d q=%0d required 2000 0", o_addr, o_quad);
    end
  endtask

  task automatic test_pending_cfg();
    i_cfg_valid = 1'b1; i_cfg_step = 12'd10; i_cfg_dir = 1'b0;
    tick();
    i_cfg_valid = 1'b0;
    checks++;
    if ({o_cfg_ready, o_addr} !== {1'b0, 12'd2000}) begin
      errors++;
      $display("FAIL pend_ready_low: ready=%b addr=%0d required 0 2000", o_cfg_ready, o_addr);
    end
    tick();
    checks++;
    if (o_cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL pend_ready_hold: ready=%b required 0", o_cfg_ready);
    end
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    checks++;
    if ({o_addr, o_cfg_ready} !== {12'd2010, 1'b1}) begin
      errors++;
      $display("FAIL pend_applied: addr=%0d ready=%b required 2010 1", o_addr, o_cfg_ready);
    end
    i_cfg_valid = 1'b1; i_cfg_step = 12'd20; i_enable = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    checks++;
    if ({o_addr, o_cfg_ready} !== {12'd2020, 1'b0}) begin
      errors++;
      $display("FAIL pend_same_cycle_old_step: addr=%0d ready=%b required 2020 0", o_addr, o_cfg_ready);
    end
    tick();
    i_enable = 1'b0;
    checks++;
    if ({o_addr, o_cfg_ready} !== {12'd2040, 1'b1}) begin
      errors++;
      $display("FAIL pend_same_cycle_new_step: addr=%0d ready=%b required 2040 1", o_addr, o_cfg_ready);
    end
  endtask

  task automatic test_start_stop();
    i_start = 1'b1; i_stop = 1'b1; i_enable = 1'b1;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
    checks++;
    if ({o_busy, o_valid, o_addr} !== {1'b0, 1'b0, 12'd2040}) begin
      errors++;
      $display("FAIL stop_wins: busy=%b valid=%b addr=%0d required 0 0 2040", o_busy, o_valid, o_addr);
    end
    tick();
    i_enable = 1'b0;
    checks++;
    if ({o_busy, o_valid, o_addr} !== {1'b0, 1'b0, 12'd2040}) begin
      errors++;
      $display("FAIL idle_ignores_enable: busy=%b valid=%b addr=%0d required 0 0 2040", o_busy, o_valid, o_addr);
    end
  endtask

  task automatic test_reset_mid_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    checks++;
    if (o_addr !== 12'd20) begin
      errors++;
      $display("FAIL mid_run_advance: addr=%0d required 20", o_addr);
    end
    i_cfg_valid = 1'b1; i_cfg_step = 12'd5;
    tick();
    i_cfg_valid = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++;
    if ({o_addr, o_quad, o_swap, o_neg_sin, o_neg_cos, o_valid, o_busy, o_cfg_err, o_cfg_ready}
        !== {12'd0, 2'd0, 7'b0000000, 1'b1}) begin
      errors++;
      $display("FAIL mid_run_reset: addr=%0d quad=%0d valid=%b busy=%b err=%b ready=%b required 0 0 0 0 0 1",
               o_addr, o_quad, o_valid, o_busy, o_cfg_err, o_cfg_ready);
    end
    i_enable = 1'b1;
    repeat (2) tick();
    i_enable = 1'b0;
    checks++;
    if ({o_addr, o_valid, o_busy} !== {12'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_strobes: addr=%0d valid=%b busy=%b required 0 0 0", o_addr, o_valid, o_busy);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    checks++;
    if ({o_addr, o_quad, o_valid, o_busy} !== {12'd0, 2'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_step_strobe: addr=%0d quad=%0d valid=%b busy=%b required 0 0 1 1",
               o_addr, o_quad, o_valid, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_illegal_step();
    test_pending_cfg();
    test_start_stop();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
